// File: rtl/alu_arbiter.sv
// Arbitrates two valid/ready requesters onto one external combinational ALU.
// Holds one response at a time and owns the architectural FLAGS, which only port 0 updates.
module alu_arbiter #(
  parameter int unsigned      DATA_W       = 16,
  parameter int unsigned      OPX_W        = 4,
  parameter int unsigned      STARVE_LIMIT = 4,
  parameter logic [OPX_W-1:0] OPX_MOV      = '0
) (
  input  logic              CLK,
  input  logic              RESET_N,

  input  logic              REQ0_VALID,
  output logic              REQ0_READY,
  input  logic [OPX_W-1:0]  REQ0_ALUX,
  input  logic [DATA_W-1:0] REQ0_ARGA,
  input  logic [DATA_W-1:0] REQ0_ARGB,

  input  logic              REQ1_VALID,
  output logic              REQ1_READY,
  input  logic [OPX_W-1:0]  REQ1_ALUX,
  input  logic [DATA_W-1:0] REQ1_ARGA,
  input  logic [DATA_W-1:0] REQ1_ARGB,

  output logic              RSP0_VALID,
  input  logic              RSP0_READY,
  output logic              RSP1_VALID,
  input  logic              RSP1_READY,
  output logic [DATA_W-1:0] RSP_RESULT,
  output logic [3:0]        RSP_FLAGS,

  output logic [OPX_W-1:0]  ALU_ALUX,
  output logic [DATA_W-1:0] ALU_ARGA,
  output logic [DATA_W-1:0] ALU_ARGB,
  input  logic [DATA_W-1:0] ALU_RESULT,
  input  logic              ALU_SIGN,
  input  logic              ALU_CARRY,
  input  logic              ALU_ZERO,
  input  logic              ALU_PARITY,

  output logic [3:0]        FLAGS
);

  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [3:0]          starve_q, starve_d;
  logic [OPX_W-1:0]    alux_q, alux_d;
  logic [DATA_W-1:0]   arga_q, arga_d;
  logic [DATA_W-1:0]   argb_q, argb_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [3:0]          rflags_q, rflags_d;
  logic [3:0]          flags_q, flags_d;

  logic                grant0, grant1;
  logic                hs0, hs1;
  logic                rsp_ready_sel;
  logic [OPX_W-1:0]    sel_alux;
  logic [DATA_W-1:0]   sel_arga, sel_argb;
  logic [3:0]          alu_flags;

  // Port 0 wins unless port 1 has waited through STARVE_LIMIT port-0 grants.
  always_comb begin
    grant1 = REQ1_VALID && (!REQ0_VALID || (starve_q == StarveLim));
    grant0 = REQ0_VALID && !grant1;
  end

  always_comb begin
    hs0 = (state_q == StIdle) && grant0;
    hs1 = (state_q == StIdle) && grant1;
  end

  always_comb begin
    sel_alux = grant1 ? REQ1_ALUX : REQ0_ALUX;
    sel_arga = grant1 ? REQ1_ARGA : REQ0_ARGA;
    sel_argb = grant1 ? REQ1_ARGB : REQ0_ARGB;
  end

  always_comb begin
    alu_flags     = {ALU_SIGN, ALU_CARRY, ALU_ZERO, ALU_PARITY};
    rsp_ready_sel = owner_q ? RSP1_READY : RSP0_READY;
  end

  always_comb begin
    starve_d = starve_q;
    if (!REQ1_VALID || hs1) begin
      starve_d = '0;
    end else if (hs0 && (starve_q != 4'hF)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    alux_d   = alux_q;
    arga_d   = arga_q;
    argb_d   = argb_q;
    result_d = result_q;
    rflags_d = rflags_q;
    flags_d  = flags_q;

    unique case (state_q)
      StIdle: begin
        if (hs0 || hs1) begin
          alux_d  = sel_alux;
          arga_d  = sel_arga;
          argb_d  = sel_argb;
          owner_d = hs1;
          state_d = StExec;
        end
      end
      StExec: begin
        result_d = ALU_RESULT;
        rflags_d = alu_flags;
        if (!owner_q) begin
          flags_d = alu_flags;
        end
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready_sel) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      starve_q <= '0;
      alux_q   <= OPX_MOV;
      arga_q   <= '0;
      argb_q   <= '0;
      result_q <= '0;
      rflags_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      alux_q   <= alux_d;
      arga_q   <= arga_d;
      argb_q   <= argb_d;
      result_q <= result_d;
      rflags_q <= rflags_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    REQ0_READY = hs0;
    REQ1_READY = hs1;
    RSP0_VALID = (state_q == StResp) && !owner_q;
    RSP1_VALID = (state_q == StResp) && owner_q;
    RSP_RESULT = result_q;
    RSP_FLAGS  = rflags_q;
    ALU_ALUX   = alux_q;
    ALU_ARGA   = arga_q;
    ALU_ARGB   = argb_q;
    FLAGS      = flags_q;
  end

  a_one_ready: assert property (@(posedge CLK) disable iff (!RESET_N)
    !(REQ0_READY && REQ1_READY));

  a_ready_idle_only: assert property (@(posedge CLK) disable iff (!RESET_N)
    (state_q != StIdle) |-> !(REQ0_READY || REQ1_READY));

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a cycle-level reference model,
// with a behavioural ALU attached to the ALU_* interface.
module tb_alu_arbiter;

  localparam int unsigned LIMIT = 4;
  localparam logic [3:0] OP_MOV = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_CMP = 4'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, rr0 = 1'b0, rr1 = 1'b0;
  logic [3:0]  op0 = '0, op1 = '0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        rdy0, rdy1, rsp0v, rsp1v;
  logic [15:0] rsp_result, alu_arga, alu_argb, alu_result;
  logic [3:0]  rsp_flags, flags, alu_alux;
  logic        alu_sign, alu_carry, alu_zero, alu_parity;

  always #5 clk = ~clk;

  alu_arbiter #(
    .DATA_W      (16),
    .OPX_W       (4),
    .STARVE_LIMIT(LIMIT),
    .OPX_MOV     (OP_MOV)
  ) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .REQ0_VALID (v0),
    .REQ0_READY (rdy0),
    .REQ0_ALUX  (op0),
    .REQ0_ARGA  (a0),
    .REQ0_ARGB  (b0),
    .REQ1_VALID (v1),
    .REQ1_READY (rdy1),
    .REQ1_ALUX  (op1),
    .REQ1_ARGA  (a1),
    .REQ1_ARGB  (b1),
    .RSP0_VALID (rsp0v),
    .RSP0_READY (rr0),
    .RSP1_VALID (rsp1v),
    .RSP1_READY (rr1),
    .RSP_RESULT (rsp_result),
    .RSP_FLAGS  (rsp_flags),
    .ALU_ALUX   (alu_alux),
    .ALU_ARGA   (alu_arga),
    .ALU_ARGB   (alu_argb),
    .ALU_RESULT (alu_result),
    .ALU_SIGN   (alu_sign),
    .ALU_CARRY  (alu_carry),
    .ALU_ZERO   (alu_zero),
    .ALU_PARITY (alu_parity),
    .FLAGS      (flags)
  );

  // Returns {S,C,Z,P,result}; P is overflow for arithmetic ops, even parity otherwise.
  function automatic logic [19:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    logic        c, p;
    w = '0; c = 1'b0;
    case (op)
      OP_MOV: begin r = b; p = ~^r; end
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
        p = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_SUB, OP_CMP: begin
        w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16];
        p = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OP_AND: begin r = a & b; p = ~^r; end
      OP_OR:  begin r = a | b; p = ~^r; end
      OP_XOR: begin r = a ^ b; p = ~^r; end
      default: begin r = a; p = ~^r; end
    endcase
    return {r[15], c, (r == 16'h0), p, r};
  endfunction

  always_comb {alu_sign, alu_carry, alu_zero, alu_parity, alu_result} =
      alu_fn(alu_alux, alu_arga, alu_argb);

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Reference model: phase 0 = free, 1 = computing, 2 = holding response.
  int          m_phase, m_owner, m_starve;
  logic [15:0] m_res;
  logic [3:0]  m_rfl, m_flags;
  bit          hs0, hs1;
  bit          keep0, keep1, rnd_mode;
  int          obs_q[$];
  int          hs0_cyc[$];
  logic        s_rdy0, s_rdy1, s_rsp0v, s_rsp1v;
  logic [15:0] s_result;
  logic [3:0]  s_rflags, s_flags;

  function automatic void model_reset();
    m_phase = 0; m_owner = 0; m_starve = 0; m_res = '0; m_rfl = '0; m_flags = '0;
    hs0 = 0; hs1 = 0;
  endfunction

  task automatic model_step();
    int win;
    win = -1;
    if (m_phase == 0) begin
      if (v1 && (!v0 || m_starve == LIMIT)) win = 1;
      else if (v0) win = 0;
    end
    check_eq("req0_ready", 32'(rdy0), 32'(win == 0));
    check_eq("req1_ready", 32'(rdy1), 32'(win == 1));
    check_eq("rsp0_valid", 32'(rsp0v), 32'(m_phase == 2 && m_owner == 0));
    check_eq("rsp1_valid", 32'(rsp1v), 32'(m_phase == 2 && m_owner == 1));
    check_eq("flags_reg", 32'(flags), 32'(m_flags));
    if (m_phase == 2) begin
      check_eq("rsp_result", 32'(rsp_result), 32'(m_res));
      check_eq("rsp_flags", 32'(rsp_flags), 32'(m_rfl));
    end
    hs0 = (win == 0);
    hs1 = (win == 1);
    case (m_phase)
      0: if (win >= 0) begin
        if (win == 0) {m_rfl, m_res} = alu_fn(op0, a0, b0);
        else          {m_rfl, m_res} = alu_fn(op1, a1, b1);
        m_owner = win;
        m_phase = 1;
      end
      1: begin
        if (m_owner == 0) m_flags = m_rfl;
        m_phase = 2;
      end
      default: if ((m_owner == 0) ? rr0 : rr1) m_phase = 0;
    endcase
    if (!v1 || win == 1) m_starve = 0;
    else if (win == 0) m_starve++;
  endtask

  // Called at posedge+1; samples at the next negedge, then returns at the next posedge+1.
  task automatic tick();
    @(negedge clk);
    cyc++;
    s_rdy0 = rdy0; s_rdy1 = rdy1; s_rsp0v = rsp0v; s_rsp1v = rsp1v;
    s_result = rsp_result; s_rflags = rsp_flags; s_flags = flags;
    if (v0 && rdy0) begin obs_q.push_back(0); hs0_cyc.push_back(cyc); end
    if (v1 && rdy1) obs_q.push_back(1);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int port);
    if (port == 0) begin
      op0 = 4'($urandom_range(0, 7)); a0 = 16'($urandom); b0 = 16'($urandom); v0 = 1'b1;
    end else begin
      op1 = 4'($urandom_range(0, 7)); a1 = 16'($urandom); b1 = 16'($urandom); v1 = 1'b1;
    end
  endtask

  task automatic drive_next();
    if (hs0) v0 = 1'b0;
    if (hs1) v1 = 1'b0;
    if (!v0 && (keep0 || (rnd_mode && $urandom_range(0, 2) == 0))) new_req(0);
    if (!v1 && (keep1 || (rnd_mode && $urandom_range(0, 2) == 0))) new_req(1);
    if (rnd_mode) begin
      rr0 = ($urandom_range(0, 3) != 0);
      rr1 = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic step();
    tick();
    drive_next();
  endtask

  task automatic wait_rsp(input int port);
    for (int k = 0; k < 20; k++) begin
      step();
      if ((port == 0) ? s_rsp0v : s_rsp1v) return;
    end
    check_eq("rsp_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_until_grants(input int target);
    for (int k = 0; k < 400; k++) begin
      if (obs_q.size() >= target) return;
      step();
    end
    check_eq("grant_timeout", 32'(obs_q.size()), 32'(target));
  endtask

  task automatic drain();
    keep0 = 0; keep1 = 0; rnd_mode = 0; rr0 = 1'b1; rr1 = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (!v0 && !v1 && m_phase == 0) return;
      step();
    end
    check_eq("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic release_reset();
    v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  int base;
  int lat;
  logic [15:0] held;

  initial begin
    model_reset();
    keep0 = 0; keep1 = 0; rnd_mode = 0;
    release_reset();

    // Reset state
    check_eq("rst_alux", 32'(alu_alux), 32'(OP_MOV));
    check_eq("rst_arga", 32'(alu_arga), 32'd0);
    check_eq("rst_argb", 32'(alu_argb), 32'd0);
    check_eq("rst_result", 32'(rsp_result), 32'd0);
    check_eq("rst_rflags", 32'(rsp_flags), 32'd0);
    check_eq("rst_flags", 32'(flags), 32'd0);
    check_eq("rst_rspv", 32'({rsp0v, rsp1v}), 32'd0);

    // Port 0 ADD with signed overflow
    rr0 = 1'b1; op0 = OP_ADD; a0 = 16'h7FFF; b0 = 16'h0001; v0 = 1'b1;
    step();
    base = cyc;
    wait_rsp(0);
    lat = cyc - base;
    check_eq("add_latency", 32'(lat), 32'd2);
    check_eq("add_result", 32'(s_result), 32'h8000);
    check_eq("add_rflags", 32'(s_rflags), 32'b1001);
    check_eq("add_flags", 32'(s_flags), 32'b1001);

    // Port 1 SUB leaves FLAGS alone
    rr1 = 1'b1; op1 = OP_SUB; a1 = 16'd5; b1 = 16'd5; v1 = 1'b1;
    wait_rsp(1);
    check_eq("sub_result", 32'(s_result), 32'h0);
    check_eq("sub_rflags", 32'(s_rflags), 32'b0010);
    check_eq("sub_flags", 32'(s_flags), 32'b1001);
    step();

    // Starvation: both always valid -> 0,0,0,0,1 repeating
    obs_q.delete();
    keep0 = 1; keep1 = 1; rr0 = 1'b1; rr1 = 1'b1;
    drive_next();
    run_until_grants(10);
    for (int i = 0; i < 10; i++)
      check_eq("starve_order", 32'(obs_q[i]), 32'((i % 5) == 4));
    run_until_grants(12);
    // Dropping REQ1_VALID for a cycle must clear the count
    keep1 = 0; v1 = 1'b0;
    step();
    keep1 = 1; v1 = 1'b1;
    run_until_grants(17);
    for (int i = 12; i < 17; i++)
      check_eq("starve_clear", 32'(obs_q[i]), 32'(i == 16));
    drain();

    // Response held off for 10 cycles
    rr0 = 1'b0; op0 = OP_XOR; a0 = 16'hA5A5; b0 = 16'h0FF0; v0 = 1'b1;
    wait_rsp(0);
    held = s_result;
    check_eq("hold_first", 32'(held), 32'h AA55);
    new_req(0); new_req(1);
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("hold_result", 32'(s_result), 32'(held));
      check_eq("hold_ready", 32'({s_rdy0, s_rdy1}), 32'd0);
    end
    rr0 = 1'b1;
    step();
    obs_q.delete();
    step();
    check_eq("hold_accept", 32'(s_rdy0), 32'd1);
    check_eq("hold_accept_n", 32'(obs_q.size()), 32'd1);
    drain();

    // Back-to-back port-0 with response ready tied high
    hs0_cyc.delete();
    keep0 = 1; rr0 = 1'b1;
    drive_next();
    for (int k = 0; k < 60 && hs0_cyc.size() < 5; k++) step();
    check_eq("b2b_count", 32'(hs0_cyc.size() >= 5), 32'd1);
    for (int i = 0; i + 1 < hs0_cyc.size() && i < 4; i++)
      check_eq("b2b_spacing", 32'(hs0_cyc[i+1] - hs0_cyc[i]), 32'd3);
    drain();

    // Reset while a port-0 response is held
    rr0 = 1'b0; op0 = OP_SUB; a0 = 16'd1; b0 = 16'd2; v0 = 1'b1;
    wait_rsp(0);
    check_eq("pre_rst_flags", 32'(s_flags), 32'b1100);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_rsp0v", 32'(rsp0v), 32'd0);
    check_eq("midrst_flags", 32'(flags), 32'd0);
    check_eq("midrst_alux", 32'(alu_alux), 32'(OP_MOV));
    check_eq("midrst_result", 32'(rsp_result), 32'd0);
    release_reset();

    // Random traffic
    rnd_mode = 1;
    for (int i = 0; i < 3000; i++) step();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
